// File: rtl/prog_tick_divider_if.sv
// Control/status bundle for prog_tick_divider: global enable, per-channel config
// write port, and the registered tick/sq/done/scan_idx outputs.
interface prog_tick_divider_if #(
  parameter int CH_W   = 2,
  parameter int CNT_W  = 16,
  parameter int SCAN_W = 2
);
  localparam int NUM_CH = 2 ** CH_W;

  logic              en;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] done;
  logic [SCAN_W-1:0] scan_idx;

  modport master (
    output en, cfg_we, cfg_ch, cfg_div, cfg_mode,
    input  tick, sq, done, scan_idx
  );

  modport slave (
    input  en, cfg_we, cfg_ch, cfg_div, cfg_mode,
    output tick, sq, done, scan_idx
  );
endinterface

// File: rtl/prog_tick_divider.sv
// Multi-channel programmable clock-enable generator with periodic/one-shot modes
// and a display scan index. Square outputs exist only when SQ_OUT_EN is defined.
module prog_tick_divider #(
  parameter int          CH_W        = 2,
  parameter int          CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 49999,
  parameter int          SCAN_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  prog_tick_divider_if.slave    bus
);
  localparam int NUM_CH = 2 ** CH_W;
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] sq_vec;
  logic [NUM_CH-1:0] done_vec;
  logic [SCAN_W-1:0] scan_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_reg, div_next;
    logic             mode_reg, mode_next;
    logic             run_reg, run_next;
    logic             tick_reg, tick_next;
    logic             done_reg, done_next;
    logic             sel;

    assign sel = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

    // A config write to this channel takes priority over a coincident terminal count.
    always_comb begin
      cnt_next  = cnt_reg;
      div_next  = div_reg;
      mode_next = mode_reg;
      run_next  = run_reg;
      done_next = done_reg;
      tick_next = 1'b0;
      if (sel) begin
        div_next  = bus.cfg_div;
        mode_next = bus.cfg_mode;
        cnt_next  = '0;
        run_next  = 1'b1;
        done_next = 1'b0;
      end else if (bus.en && run_reg) begin
        if (cnt_reg == div_reg) begin
          cnt_next  = '0;
          tick_next = 1'b1;
          if (mode_reg) begin
            run_next  = 1'b0;
            done_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg  <= '0;
        div_reg  <= DIV_INIT;
        mode_reg <= 1'b0;
        run_reg  <= 1'b1;
        tick_reg <= 1'b0;
        done_reg <= 1'b0;
      end else begin
        cnt_reg  <= cnt_next;
        div_reg  <= div_next;
        mode_reg <= mode_next;
        run_reg  <= run_next;
        tick_reg <= tick_next;
        done_reg <= done_next;
      end
    end

`ifdef SQ_OUT_EN
    logic sq_reg;

    // Toggles on the same edge the tick is registered, so its period is twice the tick period.
    always_ff @(posedge clk) begin
      if (rst || sel) begin
        sq_reg <= 1'b0;
      end else if (tick_next) begin
        sq_reg <= ~sq_reg;
      end
    end

    assign sq_vec[gi] = sq_reg;
`else
    assign sq_vec[gi] = 1'b0;
`endif

    assign tick_vec[gi] = tick_reg;
    assign done_vec[gi] = done_reg;
  end

  // Advances one cycle after tick[0] becomes visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_reg <= '0;
    end else begin
      scan_reg <= scan_reg + SCAN_W'(tick_vec[0]);
    end
  end

  assign bus.tick     = tick_vec;
  assign bus.sq       = sq_vec;
  assign bus.done     = done_vec;
  assign bus.scan_idx = scan_reg;
endmodule

// File: tb/tb_prog_tick_divider.sv
// Scoreboard bench for prog_tick_divider: a cycle model pushes expected outputs
// per edge, each scenario task pops and compares them, plus directed timing checks.
module tb_prog_tick_divider;
  localparam int CH_W = 2, CNT_W = 16, SCAN_W = 2, NUM_CH = 4, DIV_DEF = 4;
`ifdef SQ_OUT_EN
  localparam bit SQ_ON = 1'b1;
`else
  localparam bit SQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_tick_divider_if #(.CH_W(CH_W), .CNT_W(CNT_W), .SCAN_W(SCAN_W)) dif ();

  prog_tick_divider #(
    .CH_W(CH_W), .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEF), .SCAN_W(SCAN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  logic [CNT_W-1:0]  m_cnt [NUM_CH];
  logic [CNT_W-1:0]  m_div [NUM_CH];
  logic [NUM_CH-1:0] m_mode, m_run, m_tick, m_sq, m_done;
  logic [SCAN_W-1:0] m_scan;
  logic [13:0]       exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;

  // Reference behaviour for one clock edge, from the block's description.
  task automatic model_step(input logic r, input logic e, input logic we,
                            input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv,
                            input logic md);
    if (r) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = '0; m_div[c] = CNT_W'(DIV_DEF);
        m_mode[c] = 0; m_run[c] = 1; m_tick[c] = 0; m_sq[c] = 0; m_done[c] = 0;
      end
      m_scan = '0;
    end else begin
      m_scan = m_scan + SCAN_W'(m_tick[0]);
      for (int c = 0; c < NUM_CH; c++) begin
        if (we && ch == CH_W'(c)) begin
          m_div[c] = dv; m_mode[c] = md; m_cnt[c] = '0;
          m_sq[c] = 0; m_run[c] = 1; m_done[c] = 0; m_tick[c] = 0;
        end else if (e && m_run[c]) begin
          if (m_cnt[c] == m_div[c]) begin
            m_cnt[c] = '0; m_tick[c] = 1; m_sq[c] = ~m_sq[c];
            if (m_mode[c]) begin
              m_run[c] = 0; m_done[c] = 1;
            end
          end else begin
            m_cnt[c] = m_cnt[c] + CNT_W'(1); m_tick[c] = 0;
          end
        end else begin
          m_tick[c] = 0;
        end
      end
    end
    exp_q.push_back({m_tick, (SQ_ON ? m_sq : 4'b0000), m_done, m_scan});
  endtask

  // Drive inputs for one edge, record expectation, sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic we,
                     input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv, input logic md);
    rst = r; dif.en = e; dif.cfg_we = we; dif.cfg_ch = ch; dif.cfg_div = dv; dif.cfg_mode = md;
    model_step(r, e, we, ch, dv, md);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] observed();
    return {dif.tick, dif.sq, dif.done, dif.scan_idx};
  endfunction

  task automatic test_reset;
    logic [13:0] e, got;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 2'd1, 16'd7, 1'b1);
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL reset_sb: got %h expected %h", got, e); end
      n_cmp++; if (got !== 14'd0) begin n_bad++; $display("FAIL reset_zero: got %h expected 0", got); end
    end
  endtask

  task automatic test_periodic;
    logic [13:0] e, got;
    int first = -1, cnt0 = 0;
    for (int i = 1; i <= 25; i++) begin
      cyc(0, 1, 0, 2'd0, 16'd0, 1'b0);
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL periodic_sb cyc %0d: got %h expected %h", i, got, e); end
      if (dif.tick[0] === 1'b1) begin cnt0++; if (first < 0) first = i; end
    end
    n_cmp++; if (first != 5) begin n_bad++; $display("FAIL periodic_first: got %0d expected 5", first); end
    n_cmp++; if (cnt0 != 5) begin n_bad++; $display("FAIL periodic_count: got %0d expected 5", cnt0); end
    n_cmp++; if (dif.done !== 4'b0) begin n_bad++; $display("FAIL periodic_done: got %b expected 0000", dif.done); end
  endtask

  task automatic test_div0;
    logic [13:0] e, got;
    int n1 = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i == 0) cyc(0, 1, 1, 2'd1, 16'd0, 1'b0);
      else        cyc(0, 1, 0, 2'd0, 16'd0, 1'b0);
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL div0_sb cyc %0d: got %h expected %h", i, got, e); end
      if (i > 0 && dif.tick[1] === 1'b1) n1++;
    end
    n_cmp++; if (n1 != 12) begin n_bad++; $display("FAIL div0_ticks: got %0d expected 12", n1); end
  endtask

  task automatic test_oneshot;
    logic [13:0] e, got;
    int n2 = 0, at = -1;
    for (int i = 0; i <= 54; i++) begin
      if (i == 0) cyc(0, 1, 1, 2'd2, 16'd3, 1'b1);
      else        cyc(0, 1, 0, 2'd0, 16'd0, 1'b0);
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL oneshot_sb cyc %0d: got %h expected %h", i, got, e); end
      if (dif.tick[2] === 1'b1) begin n2++; at = i; end
      if (i == 3) begin
        n_cmp++; if (dif.done[2] !== 1'b0) begin n_bad++; $display("FAIL oneshot_early_done: got %b expected 0", dif.done[2]); end
      end
      if (i == 4) begin
        n_cmp++; if (dif.done[2] !== 1'b1) begin n_bad++; $display("FAIL oneshot_done: got %b expected 1", dif.done[2]); end
      end
    end
    n_cmp++; if (n2 != 1 || at != 4) begin n_bad++; $display("FAIL oneshot_ticks: got %0d at %0d expected 1 at 4", n2, at); end
    cyc(0, 1, 1, 2'd2, 16'd3, 1'b0);
    got = observed(); e = exp_q.pop_front();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL oneshot_clr_sb: got %h expected %h", got, e); end
    n_cmp++; if (dif.done[2] !== 1'b0) begin n_bad++; $display("FAIL oneshot_clear: got %b expected 0", dif.done[2]); end
  endtask

  task automatic test_en_hold;
    logic [13:0] e, got;
    logic sq0;
    int edges = 0, guard = 0;
    bit seen = 0;
    while (m_cnt[0] != 16'd2 && guard < 20) begin
      cyc(0, 1, 0, 2'd0, 16'd0, 1'b0); guard++;
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL enhold_pre_sb: got %h expected %h", got, e); end
    end
    sq0 = dif.sq[0];
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 2'd0, 16'd0, 1'b0); edges++;
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL enhold_pause_sb %0d: got %h expected %h", i, got, e); end
      n_cmp++; if (dif.sq[0] !== sq0) begin n_bad++; $display("FAIL enhold_sq: got %b expected %b", dif.sq[0], sq0); end
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 1, 0, 2'd0, 16'd0, 1'b0); edges++;
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL enhold_post_sb: got %h expected %h", got, e); end
      if (dif.tick[0] === 1'b1) seen = 1;
    end
    n_cmp++; if (!seen || edges != 10) begin n_bad++; $display("FAIL enhold_delay: got %0d edges expected 10", edges); end
  endtask

  task automatic test_write_at_tc;
    logic [13:0] e, got;
    int edges = 0, guard = 0;
    bit seen = 0;
    while (m_cnt[0] != 16'd4 && guard < 20) begin
      cyc(0, 1, 0, 2'd0, 16'd0, 1'b0); guard++;
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL wrtc_pre_sb: got %h expected %h", got, e); end
    end
    cyc(0, 1, 1, 2'd0, 16'd4, 1'b0);
    got = observed(); e = exp_q.pop_front();
    n_cmp++; if (got !== e) begin n_bad++; $display("FAIL wrtc_sb: got %h expected %h", got, e); end
    n_cmp++; if (dif.tick[0] !== 1'b0) begin n_bad++; $display("FAIL wrtc_notick: got %b expected 0", dif.tick[0]); end
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 1, 0, 2'd0, 16'd0, 1'b0); edges++;
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL wrtc_post_sb: got %h expected %h", got, e); end
      if (dif.tick[0] === 1'b1) seen = 1;
    end
    n_cmp++; if (!seen || edges != 5) begin n_bad++; $display("FAIL wrtc_next: got %0d edges expected 5", edges); end
  endtask

  task automatic test_scan_and_rst;
    logic [13:0] e, got;
    logic [SCAN_W-1:0] want [4];
    int k = 0, edges = 0;
    bit prev = 0, seen = 0;
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
    cyc(1, 0, 0, 2'd0, 16'd0, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 21; i++) begin
      cyc(0, 1, 0, 2'd0, 16'd0, 1'b0);
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL scan_sb cyc %0d: got %h expected %h", i, got, e); end
      if (prev && k < 4) begin
        n_cmp++; if (dif.scan_idx !== want[k]) begin n_bad++; $display("FAIL scan_step %0d: got %0d expected %0d", k, dif.scan_idx, want[k]); end
        k++;
      end
      prev = dif.tick[0];
    end
    n_cmp++; if (k != 4) begin n_bad++; $display("FAIL scan_steps: got %0d expected 4", k); end
    cyc(0, 1, 1, 2'd0, 16'd9, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0, 2'd0, 16'd0, 1'b0); void'(exp_q.pop_front()); end
    cyc(1, 1, 0, 2'd0, 16'd0, 1'b0);
    got = observed(); e = exp_q.pop_front();
    n_cmp++; if (got !== 14'd0) begin n_bad++; $display("FAIL midrst_zero: got %h expected 0", got); end
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(0, 1, 0, 2'd0, 16'd0, 1'b0); edges++;
      got = observed(); e = exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL midrst_sb: got %h expected %h", got, e); end
      if (dif.tick[0] === 1'b1) seen = 1;
    end
    n_cmp++; if (!seen || edges != 5) begin n_bad++; $display("FAIL midrst_div: got %0d edges expected 5", edges); end
  endtask

  initial begin
    dif.en = 0; dif.cfg_we = 0; dif.cfg_ch = '0; dif.cfg_div = '0; dif.cfg_mode = 0;
    test_reset;
    test_periodic;
    test_div0;
    test_oneshot;
    test_en_hold;
    test_write_at_tc;
    test_scan_and_rst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prog_tick_divider.md
Name: prog_tick_divider

Overview:
Multi-channel, run-time programmable clock-enable generator for the reaction-time monitor and later display/timing blocks. Each channel produces a one-cycle tick and an optional square-wave output from a per-channel divisor. It also provides a display scan index. The block is fully synchronous: no derived clocks, and every register is clocked by clk.

Parameters:
CH_W, 2, channel-select width; NUM_CH = 2**CH_W channels
CNT_W, 16, divisor/counter width
DIV_DEFAULT, 49999, divisor loaded into every channel at reset (tick period = DIV_DEFAULT+1 clk)
SCAN_W, 2, width of display scan index

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high
en  in  1  global count enable
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W  channel addressed by cfg_we
cfg_div  in  CNT_W  new divisor
cfg_mode  in  1  0 = periodic, 1 = one-shot
tick  out  NUM_CH  one-cycle pulse per channel
sq  out  NUM_CH  square output per channel
done  out  NUM_CH  sticky one-shot completion flag
scan_idx  out  SCAN_W  display digit/anode scan index

Behaviour:
- Per-channel state: div_reg[CNT_W], mode, run, cnt[CNT_W].
- Reset (rst high at a clk edge, any time): cnt=0, div_reg=DIV_DEFAULT, mode=0, run=1, tick=0, sq=0, done=0, scan_idx=0. Reset overrides cfg_we and en.
- Counting: at each edge with en=1 and run=1:
  - If cnt==div_reg: cnt<=0, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Timing:
  - tick is registered and high exactly one cycle; steady-state tick period = div_reg+1 clk.
  - sq toggles on the same edge that tick rises, giving a period of 2*(div_reg+1).
- div_reg=0: tick high every cycle; sq toggles every cycle.
- div_reg = all-ones: counter reaches max, then wraps to 0 with tick. No overflow beyond CNT_W.
- en=0: cnt and sq hold; tick=0. Config writes are still accepted.
- Config write (cfg_we=1) to channel cfg_ch:
  - div_reg<=cfg_div, mode<=cfg_mode, cnt<=0, sq<=0, run<=1, done<=0, tick<=0 for that channel.
  - After the write, the first tick is high div+1 edges later, provided en stays high.
- Write and terminal count coincide on the same channel: the write wins, no tick is emitted, and the channel restarts.
- Other channels are unaffected by a write.
- One-shot (mode=1):
  - On the terminal tick: run<=0, cnt<=0, done<=1.
  - No further ticks; sq holds.
  - done stays set until a cfg write to that channel or rst.
- scan_idx: increments on each edge where tick[0] is registered high, i.e. it advances one cycle after tick[0] is visible. It wraps modulo 2**SCAN_W.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro SQ_OUT_EN.
- Defined: sq registers are implemented and behave as described above.
- Undefined: sq is tied to constant 0, no sq flops are generated, and tick/done/scan_idx behaviour is unchanged.

Test Plan:
1. DIV_DEFAULT=4, release rst, en=1 → every tick[i] high 1 cycle every 5 cycles, first at the 5th edge after reset. sq period is 10 cycles. done=0.
2. cfg_we ch1, div=0, mode=0 → tick[1] is high continuously starting the 1st edge after the write, sq[1] toggles every cycle, and channels 0, 2, 3 keep their timing.
3. cfg_we ch2, div=3, mode=1 → single tick[2] 4 edges after the write, done[2]=1 from the same edge, and no tick[2] over the next 50 cycles. A new cfg write clears done[2].
4. Mid-count on ch0 (cnt=2, div=4), drop en for 7 cycles → the next tick[0] is delayed exactly 7 cycles and sq[0] is held throughout.
5. cfg_we ch0, div=4 on the cycle where cnt0==div0 → no tick[0] that edge; the next tick[0] comes 5 edges later.
6. 4 ticks on ch0 with SCAN_W=2 → scan_idx goes 1, 2, 3, 0. Asserting rst mid-count → all outputs are 0 and div_reg returns to DIV_DEFAULT on the next edge.
